// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_scheduler
//  Description : Multi-channel periodic event scheduler. Expired channels are
//                queued as pending flags and offered one at a time over a
//                valid/ready handshake, with round-robin arbitration.
//                Optional: TICK_SCHED_OVERRUN_EN enables sticky overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int  NCH = 4,
    parameter int  PW  = 8,
    localparam int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic [NCH-1:0] ch_en,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [PW-1:0]  cfg_period,
    output logic           evt_valid,
    output logic [CW-1:0]  evt_ch,
    input  logic           evt_ready,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] overrun
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_period [NCH];
    logic [PW-1:0]   r_cnt    [NCH];
    logic [NCH-1:0]  r_pending;
    logic [CW-1:0]   r_rr_ptr;
    logic            r_evt_valid;
    logic [CW-1:0]   r_evt_ch;

    logic [NCH-1:0]  w_cfg;
    logic [NCH-1:0]  w_acc;
    logic [NCH-1:0]  w_expire;
    logic            w_any;
    logic [CW-1:0]   w_sel;

    // A configuration write on a channel masks any same-cycle expiry there.
    always_comb begin
        w_cfg    = '0;
        w_acc    = '0;
        w_expire = '0;
        for (int i = 0; i < NCH; i++) begin
            w_cfg[i]    = cfg_we && (cfg_ch == CW'(i));
            w_acc[i]    = r_evt_valid && evt_ready && (r_evt_ch == CW'(i));
            w_expire[i] = tick && ch_en[i] && (r_period[i] != '0) &&
                          (r_cnt[i] == PW'(1)) && !w_cfg[i];
        end
    end

    // Circular scan from the round-robin pointer; lowest offset wins.
    always_comb begin
        logic [CW:0] v_sum;
        v_sum = '0;
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_rr_ptr} + (CW+1)'(k);
            if (v_sum >= (CW+1)'(NCH))
                v_sum = v_sum - (CW+1)'(NCH);
            if (r_pending[v_sum[CW-1:0]]) begin
                w_any = 1'b1;
                w_sel = v_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_period[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_pending   <= '0;
            r_rr_ptr    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_state     <= S_IDLE;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_cfg[i]) begin
                    r_period[i]  <= cfg_period;
                    r_cnt[i]     <= cfg_period;
                    r_pending[i] <= 1'b0;
                end else if (!ch_en[i]) begin
                    r_cnt[i]     <= r_period[i];
                    r_pending[i] <= 1'b0;
                end else begin
                    if (tick && (r_period[i] != '0))
                        r_cnt[i] <= (r_cnt[i] == PW'(1)) ? r_period[i]
                                                         : r_cnt[i] - PW'(1);
                    r_pending[i] <= w_expire[i] || (r_pending[i] && !w_acc[i]);
                end
            end

            // An offer is held until accepted, whatever happens to its channel.
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_evt_ch    <= w_sel;
                        r_evt_valid <= 1'b1;
                        r_state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (evt_ready) begin
                        r_evt_valid <= 1'b0;
                        r_rr_ptr    <= (r_evt_ch == CW'(NCH - 1)) ? '0
                                                                  : r_evt_ch + CW'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TICK_SCHED_OVERRUN_EN
    logic [NCH-1:0] r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_cfg[i])
                    r_overrun[i] <= 1'b0;
                else if (w_expire[i] && r_pending[i] && !w_acc[i])
                    r_overrun[i] <= 1'b1;
            end
        end
    end

    assign overrun = r_overrun;
`else
    assign overrun = '0;
`endif

    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_scheduler
//  Description : Scoreboard bench for tick_scheduler with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_scheduler;

    localparam int NCH = 4;
    localparam int PW  = 8;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick;
    logic [NCH-1:0] ch_en;
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [PW-1:0]  cfg_period;
    logic           evt_valid;
    logic [CW-1:0]  evt_ch;
    logic           evt_ready;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] overrun;

    always #5 clk = ~clk;

    tick_scheduler #(.NCH(NCH), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ch_en      (ch_en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .evt_valid  (evt_valid),
        .evt_ch     (evt_ch),
        .evt_ready  (evt_ready),
        .pending    (pending),
        .overrun    (overrun)
    );

    // Reference model state: ticks left before each channel's next expiry.
    int  m_period [NCH];
    int  m_left   [NCH];
    bit  m_pend   [NCH];
    bit  m_ovr    [NCH];
    bit  m_valid;
    int  m_ch;
    int  m_ptr;
    bit  m_rstd;
    int  exp_q [$];

    logic [NCH-1:0] e_pend;
    logic [NCH-1:0] e_ovr;
    bit             e_valid;
    int             e_ch;
    bit             e_rstd;
    bit             chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit xfer;
        int xch;
        bit op [NCH];
        bit acc;
        bit fire;
        int c;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_period[i] = 0; m_left[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
            end
            m_valid = 0; m_ch = 0; m_ptr = 0; m_rstd = 1;
            return;
        end
        m_rstd = 0;
        xfer   = m_valid && evt_ready;
        xch    = m_ch;
        for (int i = 0; i < NCH; i++) op[i] = m_pend[i];
        for (int i = 0; i < NCH; i++) begin
            acc = xfer && (xch == i);
            if (cfg_we && (int'(cfg_ch) == i)) begin
                m_period[i] = int'(cfg_period);
                m_left[i]   = int'(cfg_period);
                m_pend[i]   = 0;
                m_ovr[i]    = 0;
            end else if (!ch_en[i]) begin
                m_left[i] = m_period[i];
                m_pend[i] = 0;
            end else begin
                fire = 0;
                if (tick && m_period[i] > 0) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        fire      = 1;
                        m_left[i] = m_period[i];
                    end
                end
`ifdef TICK_SCHED_OVERRUN_EN
                if (fire && op[i] && !acc) m_ovr[i] = 1;
`endif
                m_pend[i] = fire || (op[i] && !acc);
            end
        end
        if (xfer) begin
            exp_q.push_back(xch);
            m_valid = 0;
            m_ptr   = (xch + 1) % NCH;
        end else if (!m_valid) begin
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (op[c]) begin
                    m_valid = 1;
                    m_ch    = c;
                    break;
                end
            end
        end
    endtask

    // One clock of stimulus: capture what the DUT should now show, then drive.
    task automatic cyc(input bit r, input bit t, input logic [NCH-1:0] en,
                       input bit we, input int ch, input int per, input bit rdy);
        @(posedge clk);
        #2;
        for (int i = 0; i < NCH; i++) begin
            e_pend[i] = m_pend[i];
            e_ovr[i]  = m_ovr[i];
        end
        e_valid    = m_valid;
        e_ch       = m_ch;
        e_rstd     = m_rstd;
        chk_en     = 1'b1;
        rst        = r;
        tick       = t;
        ch_en      = en;
        cfg_we     = we;
        cfg_ch     = CW'(ch);
        cfg_period = PW'(per);
        evt_ready  = rdy;
        model_step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("evt_valid", int'(evt_valid), int'(e_valid));
            check("pending",   int'(pending),   int'(e_pend));
            check("overrun",   int'(overrun),   int'(e_ovr));
            if (e_valid || e_rstd)
                check("evt_ch", int'(evt_ch), e_ch);
            if (!rst && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_unexpected: got ch %0d, expected no transfer at %0t",
                             evt_ch, $time);
                end else begin
                    check("grant_ch", int'(evt_ch), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NCH-1:0] ren;
        rst = 1'b1; tick = 1'b0; ch_en = '0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_period = '0; evt_ready = 1'b0;
        model_step();

        // Reset held with random inputs
        for (int n = 0; n < 2; n++)
            cyc(1, $urandom_range(0, 1) == 1, NCH'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 1) == 1);

        // Period 3 on ch0
        cyc(0, 0, 4'hF, 1, 0, 3, 1);
        for (int n = 0; n < 20; n++) cyc(0, 1, 4'hF, 0, 0, 0, 1);

        // All channels period 1
        cyc(1, 0, 4'hF, 0, 0, 0, 1);
        for (int c = 0; c < NCH; c++) cyc(0, 0, 4'hF, 1, c, 1, 1);
        for (int n = 0; n < 30; n++) cyc(0, 1, 4'hF, 0, 0, 0, 1);

        // ch2 period 1 with a stalled consumer, then reconfigured while offered
        cyc(1, 0, 4'hF, 0, 0, 0, 0);
        cyc(0, 0, 4'hF, 1, 2, 1, 0);
        for (int n = 0; n < 6; n++) cyc(0, 1, 4'hF, 0, 0, 0, 0);
        cyc(0, 0, 4'hF, 1, 2, 5, 0);
        cyc(0, 0, 4'hF, 0, 0, 0, 0);
        for (int n = 0; n < 14; n++) cyc(0, 1, 4'hF, 0, 0, 0, 1);

        // ch1 period 4, disabled after 2 ticks, then re-enabled
        cyc(1, 0, 4'hF, 0, 0, 0, 1);
        cyc(0, 0, 4'hF, 1, 1, 4, 1);
        for (int n = 0; n < 2; n++) cyc(0, 1, 4'hF, 0, 0, 0, 1);
        for (int n = 0; n < 3; n++) cyc(0, 1, 4'hD, 0, 0, 0, 1);
        for (int n = 0; n < 12; n++) cyc(0, 1, 4'hF, 0, 0, 0, 1);

        // Randomised traffic with occasional reconfiguration and reset
        for (int n = 0; n < 3000; n++) begin
            ren = NCH'($urandom) | NCH'($urandom);
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, ren,
                $urandom_range(0, 15) == 0, $urandom_range(0, NCH - 1),
                $urandom_range(0, 6), $urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL grant_missing: got %0d outstanding grants, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
